// File: rtl/mdr_mult_core_if.sv
// Handshake and operand bus between the MDR controller and the shift-add multiplier core.
// The bus parameter DW must match the core's DW.
interface mdr_mult_core_if #(
  parameter int DW = 16
);
  logic              i_start;
  logic              i_abort;
  logic [DW-1:0]     i_multiplier;
  logic [DW-1:0]     i_multiplicand;
  logic              o_mcand_ld;
  logic              o_ready;
  logic              o_busy;
  logic              o_done;
  logic [2*DW-1:0]   o_product;

  modport master (
    output i_start, i_abort, i_multiplier, i_multiplicand,
    input  o_mcand_ld, o_ready, o_busy, o_done, o_product
  );

  modport slave (
    input  i_start, i_abort, i_multiplier, i_multiplicand,
    output o_mcand_ld, o_ready, o_busy, o_done, o_product
  );
endinterface

// File: rtl/mdr_mult_core.sv
// Sequential radix-2 multiplier reading the external multiplicand register every iteration.
// Define SIGNED_MULT_EN for two's-complement Booth recoding; the default build is unsigned shift-add.
module mdr_mult_core #(
  parameter int DW = 16
) (
  input  logic               clk,
  input  logic               rst,
  mdr_mult_core_if.slave     bus
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DW:0]       a_q, a_d;
  logic [DW-1:0]     q_q, q_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2*DW-1:0]   product_q, product_d;
  logic [DW:0]       sum;
`ifdef SIGNED_MULT_EN
  logic              qm1_q, qm1_d;
  logic [DW:0]       mExt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
`ifdef SIGNED_MULT_EN
      qm1_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      count_q   <= count_d;
      product_q <= product_d;
`ifdef SIGNED_MULT_EN
      qm1_q     <= qm1_d;
`endif
    end
  end

  // The multiplicand is never captured: every RUN cycle uses the live register output.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    count_d   = count_q;
    product_d = product_q;
    sum       = a_q;
`ifdef SIGNED_MULT_EN
    qm1_d     = qm1_q;
    mExt      = {bus.i_multiplicand[DW-1], bus.i_multiplicand};
`endif
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          q_d     = bus.i_multiplier;
          a_d     = '0;
          count_d = '0;
`ifdef SIGNED_MULT_EN
          qm1_d   = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.i_abort) begin
          count_d = '0;
          state_d = IDLE;
        end else begin
`ifdef SIGNED_MULT_EN
          case ({q_q[0], qm1_q})
            2'b01:   sum = a_q + mExt;
            2'b10:   sum = a_q - mExt;
            default: sum = a_q;
          endcase
          a_d   = {sum[DW], sum[DW:1]};
          qm1_d = q_q[0];
`else
          if (q_q[0]) begin
            sum = {1'b0, a_q[DW-1:0]} + {1'b0, bus.i_multiplicand};
          end
          a_d = {1'b0, sum[DW:1]};
`endif
          q_d     = {sum[0], q_q[DW-1:1]};
          count_d = count_q + CW'(1);
          if (count_q == CW'(DW - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        product_d = {a_q[DW-1:0], q_q};
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.o_mcand_ld = bus.i_start & (state_q == IDLE);
    bus.o_ready    = (state_q == IDLE);
    bus.o_busy     = (state_q == RUN);
    bus.o_done     = (state_q == DONE);
    bus.o_product  = product_q;
  end

endmodule

// File: tb/tb_mdr_mult_core.sv
// Scoreboard bench for mdr_mult_core at DW=8: directed operands, expected products queued at issue.
// Build with SIGNED_MULT_EN defined to exercise the Booth vectors instead of the unsigned ones.
module tb_mdr_mult_core;

  localparam int DW = 8;

  typedef struct {
    logic [2*DW-1:0] product;
    int              doneEdge;
  } exp_t;

  logic clk;
  logic rst;
  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   edgeCount = 0;
  int   resultsIssued = 0;
  int   resultsSeen = 0;
  int   e0;

  mdr_mult_core_if #(.DW(DW)) bus ();

  mdr_mult_core #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Issues one start at the next negedge; the accepting edge E0 is returned.
  task automatic applyStimulus(input logic [DW-1:0] mcand, input logic [DW-1:0] mplier,
                               input logic [2*DW-1:0] expected, input bit track, output int startEdge);
    @(negedge clk);
    bus.i_multiplicand = mcand;
    bus.i_multiplier   = mplier;
    bus.i_start        = 1'b1;
    #1;
    checkOutput("mcand_ld_at_start", 32'(bus.o_mcand_ld), 32'd1);
    startEdge = edgeCount + 1;
    if (track) begin
      expQ.push_back('{expected, startEdge + DW});
      resultsIssued++;
    end
    @(negedge clk);
    bus.i_start = 1'b0;
    #1;
    checkOutput("mcand_ld_in_run", 32'(bus.o_mcand_ld), 32'd0);
    checkOutput("busy_in_run", 32'(bus.o_busy), 32'd1);
  endtask

  task automatic waitResults();
    for (int i = 0; i < 40 && resultsSeen < resultsIssued; i++) @(negedge clk);
    if (resultsSeen < resultsIssued) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got %0d results expected %0d", resultsSeen, resultsIssued);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation in timing and product.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.o_done === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got done at edge %0d expected none", edgeCount);
        end else begin
          e = expQ.pop_front();
          checkOutput("done_latency", 32'(edgeCount), 32'(e.doneEdge));
          @(negedge clk);
          checkOutput("done_one_cycle", 32'(bus.o_done), 32'd0);
          checkOutput("product", 32'(bus.o_product), 32'(e.product));
          resultsSeen++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_multiplier = '0;
    bus.i_multiplicand = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_ready", 32'(bus.o_ready), 32'd1);
    checkOutput("reset_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("reset_done", 32'(bus.o_done), 32'd0);
    checkOutput("reset_product", 32'(bus.o_product), 32'd0);
    checkOutput("reset_mcand_ld", 32'(bus.o_mcand_ld), 32'd0);
    @(negedge clk);
    rst = 1'b1;

`ifdef SIGNED_MULT_EN
    $display("[TB] signed Booth vectors");
    applyStimulus(8'hFD, 8'h05, 16'hFFF1, 1'b1, e0);
    waitResults();
    applyStimulus(8'h80, 8'h80, 16'h4000, 1'b1, e0);
    waitResults();
    applyStimulus(8'h7F, 8'hFF, 16'hFF81, 1'b1, e0);
    waitResults();
`else
    $display("[TB] unsigned shift-add vectors");
    applyStimulus(8'd200, 8'd150, 16'h7530, 1'b1, e0);
    waitResults();
    applyStimulus(8'd255, 8'd255, 16'hFE01, 1'b1, e0);
    waitResults();
    applyStimulus(8'd0, 8'd173, 16'h0000, 1'b1, e0);
    waitResults();
`endif

    // A second start pulse while running must be ignored.
    applyStimulus(8'd7, 8'd9, 16'h003F, 1'b1, e0);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_multiplier = 8'd2;
    #1;
    checkOutput("mcand_ld_restart_ignored", 32'(bus.o_mcand_ld), 32'd0);
    checkOutput("busy_restart_ignored", 32'(bus.o_busy), 32'd1);
    @(negedge clk);
    bus.i_start = 1'b0;
    waitResults();

    // Abort mid-run: back to IDLE with the previous product held and no done pulse.
    applyStimulus(8'd100, 8'd3, 16'h012C, 1'b0, e0);
    repeat (3) @(negedge clk);
    bus.i_abort = 1'b1;
    @(negedge clk);
    bus.i_abort = 1'b0;
    #1;
    checkOutput("abort_ready", 32'(bus.o_ready), 32'd1);
    checkOutput("abort_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("abort_product_held", 32'(bus.o_product), 32'h003F);
    repeat (DW + 2) @(negedge clk);
    applyStimulus(8'd5, 8'd6, 16'h001E, 1'b1, e0);
    waitResults();

    // Reset mid-run clears everything immediately.
    applyStimulus(8'd100, 8'd3, 16'h012C, 1'b0, e0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_ready", 32'(bus.o_ready), 32'd1);
    checkOutput("midrst_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("midrst_done", 32'(bus.o_done), 32'd0);
    checkOutput("midrst_product", 32'(bus.o_product), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(8'd12, 8'd12, 16'h0090, 1'b1, e0);
    waitResults();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
